// File: rtl/core_host_pkg.sv
// Shared types and default sizing for the core host controller.
package core_host_pkg;

  localparam int AW_DEF      = 8;
  localparam int CW_DEF      = 16;
  localparam int TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RSTC,
    S_REQ,
    S_RUN,
    S_RDBK,
    S_DONE
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that stops at a programmable terminal value.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_term);

endmodule

// File: rtl/core_host_ctrl.sv
// Host-side run controller: preload core data memory, run the core with a
// cycle budget, then stream a window of data memory back out.
module core_host_ctrl
  import core_host_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int CW      = CW_DEF,
  parameter int RST_CYC = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    ld_len,
  input  logic [AW-1:0] rb_base,
  input  logic [7:0]    rb_len,
  input  logic [7:0]    ld_data,
  input  logic          ld_valid,
  output logic          ld_ready,
  output logic [7:0]    rb_data,
  output logic          rb_valid,
  input  logic          rb_ready,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_we,
  input  logic [7:0]    mem_rdata,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [CW-1:0] cycles
);

  state_t          r_state, w_next;
  logic [7:0]      r_ld_len, r_rb_len;
  logic [AW-1:0]   r_rb_base;
  logic            r_timed_out, r_finished;
  logic            w_accept, w_set_to;

  logic [7:0]      w_idx, w_idx_term;
  logic            w_idx_clr, w_idx_en, w_idx_tc;
  logic [CW-1:0]   w_cyc;
  logic            w_cyc_en, w_cyc_tc;

  assign w_accept = (r_state == S_IDLE) && start;

  // One counter serves LOAD index, RSTC hold and RDBK index; it restarts on every state change.
  assign w_idx_clr  = reset || (w_next != r_state);
  assign w_idx_en   = ((r_state == S_LOAD) && ld_valid) || (r_state == S_RSTC) ||
                      ((r_state == S_RDBK) && rb_ready);
  assign w_idx_term = (r_state == S_LOAD) ? r_ld_len - 8'd1 :
                      (r_state == S_RSTC) ? 8'(RST_CYC - 1) : r_rb_len - 8'd1;

  sat_counter #(.W(8)) u_idx (
    .clk    (clk),
    .i_clr  (w_idx_clr),
    .i_en   (w_idx_en),
    .i_term (w_idx_term),
    .o_cnt  (w_idx),
    .o_tc   (w_idx_tc)
  );

  assign w_cyc_en = (r_state == S_RUN) && !core_done;

  sat_counter #(.W(CW)) u_cyc (
    .clk    (clk),
    .i_clr  (reset || w_accept),
    .i_en   (w_cyc_en),
    .i_term (CW'(TIMEOUT)),
    .o_cnt  (w_cyc),
    .o_tc   (w_cyc_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ld_len    <= '0;
      r_rb_len    <= '0;
      r_rb_base   <= '0;
      r_timed_out <= 1'b0;
      r_finished  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_finished <= (r_state == S_DONE);
      if (w_accept) begin
        r_ld_len    <= ld_len;
        r_rb_len    <= rb_len;
        r_rb_base   <= rb_base;
        r_timed_out <= 1'b0;
      end else if (w_set_to) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    core_reset = 1'b1;
    core_req   = 1'b0;
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rb_valid   = 1'b0;
    rb_data    = '0;
    w_set_to   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (ld_len != 8'd0) ? S_LOAD : S_RSTC;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        mem_addr = AW'(w_idx);
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          if (w_idx_tc) w_next = S_RSTC;
        end
      end
      S_RSTC: begin
        if (w_idx_tc) w_next = S_REQ;
      end
      S_REQ: begin
        core_reset = 1'b0;
        core_req   = 1'b1;
        w_next     = S_RUN;
      end
      S_RUN: begin
        core_reset = 1'b0;
        // done wins over a count that has already saturated at TIMEOUT
        if (core_done) begin
          w_next = (r_rb_len != 8'd0) ? S_RDBK : S_DONE;
        end else if (w_cyc_tc) begin
          w_set_to = 1'b1;
          w_next   = S_DONE;
        end
      end
      S_RDBK: begin
        mem_addr = r_rb_base + AW'(w_idx);
        rb_valid = 1'b1;
        rb_data  = mem_rdata;
        if (rb_ready && w_idx_tc) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign finished  = r_finished;
  assign timed_out = r_timed_out;
  assign cycles    = w_cyc;

endmodule
